// File: rtl/fetch_pc_unit.sv
// Fetch-stage PC generator: sequential advance, decode-resolved redirects, and a
// parked redirect when fetch cannot advance. Optional counters under BRANCH_STATS_EN.
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        StallF,
    input  logic        StallD,
    input  logic        ImemReadyF,
    input  logic        BranchD,
    input  logic        ConditionD,
    input  logic [31:0] PCBranchD,
    input  logic        JumpD,
    input  logic [31:0] PCJumpD,
    output logic [31:0] PCF,
    output logic [31:0] PCPlus4F,
    output logic        ImemReqF,
    output logic        FlushD,
    output logic        RedirPendF
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0] BranchCnt,
    output logic [31:0] TakenCnt
`endif
);

    typedef enum logic {
        RUN  = 1'b0,
        PEND = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pend_q, pend_d;
    logic        advance;
    logic        redir;
    logic [31:0] tgt;
    logic [31:0] pc_plus4;

    assign advance  = ~StallF & ImemReadyF;
    assign redir    = ~StallD & (JumpD | (BranchD & ConditionD));
    assign tgt      = JumpD ? {PCJumpD[31:2], 2'b00} : {PCBranchD[31:2], 2'b00};
    assign pc_plus4 = pc_q + 32'd4;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        pend_d  = pend_q;
        FlushD  = 1'b0;
        case (state_q)
            RUN: begin
                if (redir) begin
                    FlushD = 1'b1;
                    if (advance) begin
                        pc_d = tgt;
                    end else begin
                        pend_d  = tgt;
                        state_d = PEND;
                    end
                end else if (advance) begin
                    pc_d = pc_plus4;
                end
            end
            PEND: begin
                // A newer redirect supersedes the parked one.
                if (redir) begin
                    FlushD = 1'b1;
                    pend_d = tgt;
                    if (advance) begin
                        pc_d    = tgt;
                        state_d = RUN;
                    end
                end else if (advance) begin
                    FlushD  = 1'b1;
                    pc_d    = pend_q;
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
            pend_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            pend_q  <= pend_d;
        end
    end

    assign PCF        = pc_q;
    assign PCPlus4F   = pc_plus4;
    assign ImemReqF   = ~rst;
    assign RedirPendF = (state_q == PEND);

`ifdef BRANCH_STATS_EN
    logic [31:0] branch_cnt_q, branch_cnt_d;
    logic [31:0] taken_cnt_q, taken_cnt_d;

    // Saturating: counters stick at all-ones.
    always_comb begin
        branch_cnt_d = branch_cnt_q;
        taken_cnt_d  = taken_cnt_q;
        if (BranchD & ~StallD) begin
            if (branch_cnt_q != 32'hFFFF_FFFF) branch_cnt_d = branch_cnt_q + 32'd1;
            if (ConditionD && taken_cnt_q != 32'hFFFF_FFFF) taken_cnt_d = taken_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            branch_cnt_q <= 32'd0;
            taken_cnt_q  <= 32'd0;
        end else begin
            branch_cnt_q <= branch_cnt_d;
            taken_cnt_q  <= taken_cnt_d;
        end
    end

    assign BranchCnt = branch_cnt_q;
    assign TakenCnt  = taken_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit: stimulus pushes expected per-cycle outputs,
// a negedge monitor pops and compares them.
module tb_fetch_pc_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        StallF, StallD, ImemReadyF, BranchD, ConditionD, JumpD;
    logic [31:0] PCBranchD, PCJumpD;
    logic [31:0] PCF, PCPlus4F;
    logic        ImemReqF, FlushD, RedirPendF;
`ifdef BRANCH_STATS_EN
    logic [31:0] BranchCnt, TakenCnt;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic        flush;
        logic        pend;
        logic        req;
    } exp_t;

    exp_t exp_q[$];

    fetch_pc_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk        (clk),
        .rst        (rst),
        .StallF     (StallF),
        .StallD     (StallD),
        .ImemReadyF (ImemReadyF),
        .BranchD    (BranchD),
        .ConditionD (ConditionD),
        .PCBranchD  (PCBranchD),
        .JumpD      (JumpD),
        .PCJumpD    (PCJumpD),
        .PCF        (PCF),
        .PCPlus4F   (PCPlus4F),
        .ImemReqF   (ImemReqF),
        .FlushD     (FlushD),
        .RedirPendF (RedirPendF)
`ifdef BRANCH_STATS_EN
        ,
        .BranchCnt  (BranchCnt),
        .TakenCnt   (TakenCnt)
`endif
    );

    always #5 clk = ~clk;

    // Monitor: compares one expected record per cycle in which one was queued.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (PCF !== e.pc || PCPlus4F !== (e.pc + 32'd4) || FlushD !== e.flush ||
                    RedirPendF !== e.pend || ImemReqF !== e.req) begin
                    errors++;
                    $display("FAIL %s: got PCF=%h P4=%h Flush=%b Pend=%b Req=%b, want PCF=%h P4=%h Flush=%b Pend=%b Req=%b",
                             e.name, PCF, PCPlus4F, FlushD, RedirPendF, ImemReqF,
                             e.pc, e.pc + 32'd4, e.flush, e.pend, e.req);
                end else begin
                    $display("ok   %s: PCF=%h Flush=%b Pend=%b Req=%b", e.name, PCF, FlushD, RedirPendF, ImemReqF);
                end
            end
        end
    end

    task automatic push_exp(input string name, input logic [31:0] pc,
                            input logic flush, input logic pend, input logic req);
        exp_t e;
        e.name  = name;
        e.pc    = pc;
        e.flush = flush;
        e.pend  = pend;
        e.req   = req;
        exp_q.push_back(e);
    endtask

    task automatic quiet();
        StallF = 0; StallD = 0; ImemReadyF = 1; BranchD = 0; ConditionD = 0;
        JumpD = 0; PCBranchD = 32'd0; PCJumpD = 32'd0;
    endtask

    // One cycle: drive inputs, queue the expected in-cycle outputs, cross the edge.
    task automatic step(input string name, input logic sf, input logic sd, input logic rdy,
                        input logic br, input logic cond, input logic [31:0] pcb,
                        input logic j, input logic [31:0] pcj,
                        input logic [31:0] exp_pc, input logic exp_flush, input logic exp_pend);
        StallF = sf; StallD = sd; ImemReadyF = rdy; BranchD = br; ConditionD = cond;
        PCBranchD = pcb; JumpD = j; PCJumpD = pcj;
        push_exp(name, exp_pc, exp_flush, exp_pend, 1'b1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        quiet();
        @(posedge clk); #1;
        push_exp("reset", 32'h0, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;

        //            name         sf sd rdy br c  pcb           j  pcj           exp_pc        fl pd
        step("t1_pc0",     0, 0, 1, 0, 0, 32'h0,        0, 32'h0,        32'h0000_0000, 0, 0);
        step("t1_pc4",     0, 0, 1, 0, 0, 32'h0,        0, 32'h0,        32'h0000_0004, 0, 0);
        step("t1_pc8",     0, 0, 1, 0, 0, 32'h0,        0, 32'h0,        32'h0000_0008, 0, 0);
        step("seq_c",      0, 0, 1, 0, 0, 32'h0,        0, 32'h0,        32'h0000_000C, 0, 0);
        step("t2_taken",   0, 0, 1, 1, 1, 32'h100,      0, 32'h0,        32'h0000_0010, 1, 0);
        step("t2_target",  0, 0, 1, 0, 0, 32'h0,        0, 32'h0,        32'h0000_0100, 0, 0);
        step("jmp_10",     0, 0, 1, 0, 0, 32'h0,        1, 32'h10,       32'h0000_0104, 1, 0);
        step("t3_ntaken",  0, 0, 1, 1, 0, 32'h100,      0, 32'h0,        32'h0000_0010, 0, 0);
        step("t3_seq",     0, 0, 1, 0, 0, 32'h0,        0, 32'h0,        32'h0000_0014, 0, 0);
        step("t4_park",    0, 0, 0, 0, 0, 32'h0,        1, 32'h203,      32'h0000_0018, 1, 0);
        step("t4_wait1",   0, 0, 0, 0, 0, 32'h0,        0, 32'h0,        32'h0000_0018, 0, 1);
        step("t4_wait2",   0, 0, 0, 0, 0, 32'h0,        0, 32'h0,        32'h0000_0018, 0, 1);
        step("t4_release", 0, 0, 1, 0, 0, 32'h0,        0, 32'h0,        32'h0000_0018, 1, 1);
        step("t4_target",  0, 0, 1, 0, 0, 32'h0,        0, 32'h0,        32'h0000_0200, 0, 0);
        step("stallf_park",1, 0, 1, 1, 1, 32'h300,      0, 32'h0,        32'h0000_0204, 1, 0);
        step("newest_wins",1, 0, 1, 0, 0, 32'h0,        1, 32'h400,      32'h0000_0204, 1, 1);
        step("pend_rel",   0, 0, 1, 0, 0, 32'h0,        0, 32'h0,        32'h0000_0204, 1, 1);
        step("pend_tgt",   0, 0, 1, 0, 0, 32'h0,        0, 32'h0,        32'h0000_0400, 0, 0);
        step("park_500",   0, 0, 0, 0, 0, 32'h0,        1, 32'h500,      32'h0000_0404, 1, 0);
        step("redir_adv",  0, 0, 1, 1, 1, 32'h600,      0, 32'h0,        32'h0000_0404, 1, 1);
        step("redir_tgt",  0, 0, 1, 0, 0, 32'h0,        0, 32'h0,        32'h0000_0600, 0, 0);
        step("t5_jwins",   0, 0, 1, 1, 1, 32'h800,      1, 32'h700,      32'h0000_0604, 1, 0);
        step("t5_stalld",  0, 1, 1, 1, 1, 32'h800,      0, 32'h0,        32'h0000_0700, 0, 0);
        step("t5_hold",    1, 1, 1, 1, 1, 32'h800,      0, 32'h0,        32'h0000_0704, 0, 0);
        step("t5_reeval",  0, 0, 1, 1, 1, 32'h800,      0, 32'h0,        32'h0000_0704, 1, 0);
        step("jmp_top",    0, 0, 1, 0, 0, 32'h0,        1, 32'hFFFF_FFFF, 32'h0000_0800, 1, 0);
        step("t6_wrap",    0, 0, 1, 0, 0, 32'h0,        0, 32'h0,        32'hFFFF_FFFC, 0, 0);
        step("t6_zero",    0, 0, 1, 0, 0, 32'h0,        0, 32'h0,        32'h0000_0000, 0, 0);
        step("t6_park",    0, 0, 0, 0, 0, 32'h0,        1, 32'h900,      32'h0000_0004, 1, 0);
        step("t6_inpend",  0, 0, 0, 0, 0, 32'h0,        0, 32'h0,        32'h0000_0004, 0, 1);

`ifdef BRANCH_STATS_EN
        checks++;
        if (BranchCnt !== 32'd6 || TakenCnt !== 32'd5) begin
            errors++;
            $display("FAIL stats: got BranchCnt=%0d TakenCnt=%0d, want 6 and 5", BranchCnt, TakenCnt);
        end else begin
            $display("ok   stats: BranchCnt=%0d TakenCnt=%0d", BranchCnt, TakenCnt);
        end
`endif

        // Reset while a redirect is parked must drop it.
        quiet();
        ImemReadyF = 1'b0;
        rst = 1'b1;
        push_exp("t6_rst_pend", 32'h0, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        step("post_rst0",  0, 0, 1, 0, 0, 32'h0,        0, 32'h0,        32'h0000_0000, 0, 0);
        step("post_rst4",  0, 0, 1, 0, 0, 32'h0,        0, 32'h0,        32'h0000_0004, 0, 0);

        // Bounded drain of the scoreboard.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d unchecked records, want 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
